alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Command-side initiator for alu_8bit. Accepts register-to-register ALU commands over a valid/ready handshake and holds a small register file. Drives the ALU operand/opcode inputs, waits out the ALU's registered latency, captures result/carry/zero, writes the result back and returns a response over a second valid/ready channel. It sits between a host/test sequencer and the ALU, and is the only master of the ALU inputs.

Parameters:
DATA_W, 8, operand/result width; must match the ALU.
NUM_REGS, 4, register file entries; address width RA_W = clog2(NUM_REGS).
ALU_LATENCY, 1, clock edges from ALU input sampling until its outputs are valid.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_load  in  1  1 = load immediate, 0 = ALU op
cmd_op  in  3  ALU opcode (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110/111 reserved)
cmd_dst  in  RA_W  destination register
cmd_src_a  in  RA_W  operand A register
cmd_src_b  in  RA_W  operand B register
cmd_imm  in  DATA_W  immediate for load
alu_a  out  DATA_W  to ALU a
alu_b  out  DATA_W  to ALU b
alu_opcode  out  3  to ALU opcode
alu_result  in  DATA_W  from ALU result
alu_carry  in  1  from ALU carry_out
alu_zero  in  1  from ALU zero
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  DATA_W  value written to rsp_dst
rsp_carry  out  1  carry/borrow of the operation
rsp_zero  out  1  result == 0
rsp_dst  out  RA_W  register written
dbg_raddr  in  RA_W  debug read address
dbg_rdata  out  DATA_W  combinational read of regfile[dbg_raddr]

Behaviour:
- Clock: single clock domain (clk). Reset: asynchronous, active-low (rst_n).
- Reset values: state IDLE; cmd_ready 1; rsp_valid 0; rsp_result/rsp_carry/rsp_zero/rsp_dst 0; alu_a/alu_b/alu_opcode 0; all regfile entries 0; latency counter 0.
- FSM states: IDLE, WAIT, RESP. cmd_ready = (state == IDLE), driven combinationally from the registered state.
- IDLE, with cmd_valid=1 and cmd_load=0, accept at edge E0:
  - register alu_a = RF[src_a], alu_b = RF[src_b], alu_opcode = cmd_op; latch cmd_dst.
  - cnt <= ALU_LATENCY; next state WAIT.
- WAIT: ALU samples its inputs at E0+1. At each edge, if cnt != 0 then cnt--. Else capture:
  - RF[dst] <= alu_result.
  - rsp_result/rsp_carry/rsp_zero <= alu_result/alu_carry/alu_zero; rsp_dst <= dst.
  - next state RESP.
  - Capture edge is E0+1+ALU_LATENCY, so with default ALU_LATENCY=1, rsp_valid rises after E0+2.
- IDLE, with cmd_valid=1 and cmd_load=1, accept at edge E0:
  - RF[dst] <= cmd_imm; rsp_result <= cmd_imm; rsp_carry <= 0; rsp_zero <= (cmd_imm == 0).
  - next state RESP; the ALU is not touched and alu_* hold their values.
- RESP: rsp_valid=1. Outputs hold stable until rsp_ready=1 at an edge, then IDLE. No new command is accepted before the next cycle, so there is one idle cycle minimum between commands.
- alu_a/alu_b/alu_opcode hold the last issued values between commands.
- Reserved opcodes 110/111 are forwarded unchanged. The ALU result (0x00, zero=1, carry=0) is written back as normal.
- NOT: alu_b is still driven from src_b and ignored by the ALU.
- src_a == src_b == dst is legal. Operands are read at accept and the write happens at capture, so there is no hazard because commands are serialized.
- cmd_* signals are ignored outside IDLE. cmd_valid may drop without being accepted.
- dbg_rdata is combinational; a write at edge E is visible just after E.
- rst_n asserted in any state returns everything to reset values immediately. An in-flight result is discarded and not written back.

Test Plan:
1. Reset: assert rst_n=0 for 2 cycles -> cmd_ready=1, rsp_valid=0, alu_a/b/opcode=0, dbg_rdata=0x00 for all addresses.
2. Load R0=0xFF, R1=0x01, then ADD dst R2 (src_a R0, src_b R1) -> after accept, alu_a=0xFF, alu_b=0x01, opcode=000; rsp_valid rises exactly 2 edges after accept; rsp_result=0x00, carry=1, zero=1; dbg R2=0x00.
3. Load R0=0x00, R1=0x01, then SUB R3=R0-R1 -> rsp_result=0xFF, carry=1, zero=0; then XOR R3=R3^R3 -> 0x00, zero=1.
4. Backpressure: issue AND 0xAA & 0x55 with rsp_ready=0 for 5 cycles -> rsp_valid=1 and rsp_result=0x00 stable throughout; cmd_ready=0 and a second command held on cmd_valid is not accepted until the cycle after the rsp handshake.
5. Reserved opcode 110 with R0=0xAB, R1=0xCD -> rsp_result=0x00, zero=1, carry=0; dst register overwritten with 0x00. NOT of 0xA5 -> 0x5A.
6. Reset mid-operation: accept ADD R2=0x10+0x20, then assert rst_n in WAIT -> rsp_valid never rises, R2 reads 0x00, cmd_ready=1 after reset release.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for alu_8bit: owns a small register file, issues register-to-register
// ALU operations or immediate loads, waits out the ALU latency and returns a response.
module alu_cmd_sequencer #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned ALU_LATENCY = 1,
  localparam int unsigned RA_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [2:0]        cmd_op,
  input  logic [RA_W-1:0]   cmd_dst,
  input  logic [RA_W-1:0]   cmd_src_a,
  input  logic [RA_W-1:0]   cmd_src_b,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic [RA_W-1:0]   rsp_dst,
  input  logic [RA_W-1:0]   dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  localparam int unsigned CNT_W = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [RA_W-1:0]     dst_q;
  logic [DATA_W-1:0]   rf [NUM_REGS];

  logic                accept_alu;
  logic                accept_load;
  logic                capture;
  logic                cnt_dec;
  logic                rf_we;
  logic [RA_W-1:0]     rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    state_nxt   = state;
    accept_alu  = 1'b0;
    accept_load = 1'b0;
    capture     = 1'b0;
    cnt_dec     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_load) begin
            accept_load = 1'b1;
            state_nxt   = RESP;
          end else begin
            accept_alu  = 1'b1;
            state_nxt   = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_dec = 1'b1;
        end else begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // A load writes the immediate at accept; an ALU op writes the captured result
  assign rf_we    = accept_load | capture;
  assign rf_waddr = accept_load ? cmd_dst : dst_q;
  assign rf_wdata = accept_load ? cmd_imm : alu_result;

  // ALU issue registers, latency counter and destination latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= 3'd0;
      cnt        <= '0;
      dst_q      <= '0;
    end else begin
      if (accept_alu) begin
        alu_a      <= rf[cmd_src_a];
        alu_b      <= rf[cmd_src_b];
        alu_opcode <= cmd_op;
        cnt        <= CNT_W'(ALU_LATENCY);
        dst_q      <= cmd_dst;
      end else if (cnt_dec) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_dst    <= '0;
    end else begin
      if (accept_load) begin
        rsp_result <= cmd_imm;
        rsp_carry  <= 1'b0;
        rsp_zero   <= (cmd_imm == '0);
        rsp_dst    <= cmd_dst;
      end else if (capture) begin
        rsp_result <= alu_result;
        rsp_carry  <= alu_carry;
        rsp_zero   <= alu_zero;
        rsp_dst    <= dst_q;
      end
    end
  end

  // Register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        rf[i] <= '0;
      end
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  assign dbg_rdata = rf[dbg_raddr];

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU stand-in and a
// register-file reference model driven by directed and random command streams.
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic [1:0] cmd_dst;
  logic [1:0] cmd_src_a;
  logic [1:0] cmd_src_b;
  logic [7:0] cmd_imm;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_opcode;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       alu_zero;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;
  logic [1:0] rsp_dst;
  logic [1:0] dbg_raddr;
  logic [7:0] dbg_rdata;

  int total = 0;
  int bad   = 0;
  logic [7:0] model_rf [4];

  alu_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_dst(rsp_dst),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {carry, result} of the 8-bit ALU; SUB carry is the borrow
  function automatic logic [8:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      default: return 9'd0;
    endcase
  endfunction

  // ALU stand-in with one registered stage
  always @(posedge clk) begin
    {alu_carry, alu_result} <= alu_ref(alu_opcode, alu_a, alu_b);
    alu_zero <= ((alu_ref(alu_opcode, alu_a, alu_b) & 9'h0FF) == 9'd0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one command, wait for its response, hold off rsp_ready for stall cycles, then handshake
  task automatic do_cmd(input logic ld, input logic [2:0] op, input logic [1:0] d,
                        input logic [1:0] sa, input logic [1:0] sb, input logic [7:0] imm,
                        input int stall, output int lat, output logic [7:0] r,
                        output logic c, output logic z, output logic [1:0] rd, output bit to);
    int n;
    to  = 1'b0;
    lat = 0;
    n   = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_dst = d;
    cmd_src_a = sa; cmd_src_b = sb; cmd_imm = imm;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) to = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_imm   = 8'($urandom);
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid) to = 1'b1;
    repeat (stall) @(posedge clk);
    #1;
    r = rsp_result; c = rsp_carry; z = rsp_zero; rd = rsp_dst;
    if (rsp_valid) begin
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 3'd0; cmd_dst = 2'd0;
    cmd_src_a = 2'd0; cmd_src_b = 2'd0; cmd_imm = 8'd0; rsp_ready = 1'b0; dbg_raddr = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if ({alu_a, alu_b, alu_opcode} !== 19'd0) begin
      bad++; $display("FAIL reset_alu got=%h/%h/%h exp=0", alu_a, alu_b, alu_opcode); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dbg_raddr = 2'(i);
      #1;
      total++; if (dbg_rdata !== 8'h00) begin bad++; $display("FAIL reset_rf[%0d] got=%h exp=00", i, dbg_rdata); end
      model_rf[i] = 8'h00;
    end
  endtask

  task automatic test_add();
    int lat; logic [7:0] r; logic c, z; logic [1:0] rd; bit to;
    do_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'hFF, 0, lat, r, c, z, rd, to);
    total++; if (to || lat != 0 || r !== 8'hFF || c !== 1'b0 || z !== 1'b0) begin
      bad++; $display("FAIL load_r0 to=%0d lat=%0d r=%h c=%b z=%b exp lat=0 r=ff c=0 z=0", to, lat, r, c, z); end
    do_cmd(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h01, 0, lat, r, c, z, rd, to);
    total++; if (to || r !== 8'h01 || rd !== 2'd1) begin
      bad++; $display("FAIL load_r1 to=%0d r=%h rd=%0d exp r=01 rd=1", to, r, rd); end
    do_cmd(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 8'h00, 0, lat, r, c, z, rd, to);
    total++; if (to || lat != 2) begin bad++; $display("FAIL add_latency to=%0d got=%0d exp=2", to, lat); end
    total++; if ({alu_a, alu_b, alu_opcode} !== {8'hFF, 8'h01, 3'd0}) begin
      bad++; $display("FAIL add_alu_inputs got=%h/%h/%h exp=ff/01/0", alu_a, alu_b, alu_opcode); end
    total++; if ({r, c, z, rd} !== {8'h00, 1'b1, 1'b1, 2'd2}) begin
      bad++; $display("FAIL add_rsp got r=%h c=%b z=%b d=%0d exp r=00 c=1 z=1 d=2", r, c, z, rd); end
    dbg_raddr = 2'd2; #1;
    total++; if (dbg_rdata !== 8'h00) begin bad++; $display("FAIL add_rf2 got=%h exp=00", dbg_rdata); end
  endtask

  task automatic test_sub_xor();
    int lat; logic [7:0] r; logic c, z; logic [1:0] rd; bit to;
    do_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h00, 0, lat, r, c, z, rd, to);
    total++; if (to || r !== 8'h00 || z !== 1'b1) begin
      bad++; $display("FAIL load_zero to=%0d r=%h z=%b exp r=00 z=1", to, r, z); end
    do_cmd(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h01, 0, lat, r, c, z, rd, to);
    do_cmd(1'b0, 3'd1, 2'd3, 2'd0, 2'd1, 8'h00, 1, lat, r, c, z, rd, to);
    total++; if (to || {r, c, z} !== {8'hFF, 1'b1, 1'b0}) begin
      bad++; $display("FAIL sub_rsp to=%0d r=%h c=%b z=%b exp r=ff c=1 z=0", to, r, c, z); end
    do_cmd(1'b0, 3'd4, 2'd3, 2'd3, 2'd3, 8'h00, 0, lat, r, c, z, rd, to);
    total++; if (to || {r, c, z} !== {8'h00, 1'b0, 1'b1}) begin
      bad++; $display("FAIL xor_self to=%0d r=%h c=%b z=%b exp r=00 c=0 z=1", to, r, c, z); end
    dbg_raddr = 2'd3; #1;
    total++; if (dbg_rdata !== 8'h00) begin bad++; $display("FAIL xor_rf3 got=%h exp=00", dbg_rdata); end
  endtask

  task automatic test_backpressure();
    int lat; logic [7:0] r; logic c, z; logic [1:0] rd; bit to; int n; bit ok;
    do_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'hAA, 0, lat, r, c, z, rd, to);
    do_cmd(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h55, 0, lat, r, c, z, rd, to);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'd2; cmd_dst = 2'd2; cmd_src_a = 2'd0; cmd_src_b = 2'd1;
    @(posedge clk);
    #1;
    // second command held on the bus while the first is in flight
    cmd_op = 3'd3; cmd_dst = 2'd3;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (!rsp_valid) begin bad++; $display("FAIL bp_timeout rsp_valid got=0 exp=1"); end
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_result !== 8'h00 || rsp_zero !== 1'b1 || cmd_ready !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
    end
    total++; if (!ok) begin bad++; $display("FAIL bp_hold stable=0 exp=1 (last v=%b r=%h rdy=%b)", rsp_valid, rsp_result, cmd_ready); end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_after_hs cmd_ready=%b rsp_valid=%b exp 1/0", cmd_ready, rsp_valid); end
    @(posedge clk); #1;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_second_accept cmd_ready=%b exp=0", cmd_ready); end
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (n != 2 || rsp_result !== 8'hFF || rsp_dst !== 2'd3) begin
      bad++; $display("FAIL bp_second_rsp lat=%0d r=%h d=%0d exp lat=2 r=ff d=3", n, rsp_result, rsp_dst); end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic test_reserved_not();
    int lat; logic [7:0] r; logic c, z; logic [1:0] rd; bit to;
    do_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'hAB, 0, lat, r, c, z, rd, to);
    do_cmd(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'hCD, 0, lat, r, c, z, rd, to);
    do_cmd(1'b0, 3'd6, 2'd1, 2'd0, 2'd1, 8'h00, 0, lat, r, c, z, rd, to);
    total++; if (to || {r, c, z} !== {8'h00, 1'b0, 1'b1} || alu_opcode !== 3'd6) begin
      bad++; $display("FAIL reserved_rsp to=%0d r=%h c=%b z=%b op=%0d exp r=00 c=0 z=1 op=6", to, r, c, z, alu_opcode); end
    dbg_raddr = 2'd1; #1;
    total++; if (dbg_rdata !== 8'h00) begin bad++; $display("FAIL reserved_rf1 got=%h exp=00", dbg_rdata); end
    do_cmd(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'hA5, 0, lat, r, c, z, rd, to);
    do_cmd(1'b0, 3'd5, 2'd3, 2'd2, 2'd0, 8'h00, 0, lat, r, c, z, rd, to);
    total++; if (to || {r, c, z} !== {8'h5A, 1'b0, 1'b0} || alu_b !== 8'hAB) begin
      bad++; $display("FAIL not_rsp to=%0d r=%h c=%b z=%b alu_b=%h exp r=5a c=0 z=0 alu_b=ab", to, r, c, z, alu_b); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [7:0] r; logic c, z; logic [1:0] rd; bit to; bit seen;
    do_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h10, 0, lat, r, c, z, rd, to);
    do_cmd(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h20, 0, lat, r, c, z, rd, to);
    do_cmd(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'h77, 0, lat, r, c, z, rd, to);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'd0; cmd_dst = 2'd2; cmd_src_a = 2'd0; cmd_src_b = 2'd1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL mid_in_wait cmd_ready=%b exp=0", cmd_ready); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || alu_a !== 8'h00) begin
      bad++; $display("FAIL mid_async v=%b rdy=%b alu_a=%h exp 0/1/00", rsp_valid, cmd_ready, alu_a); end
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    total++; if (seen || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL mid_after seen_valid=%0d rdy=%b exp 0/1", seen, cmd_ready); end
    dbg_raddr = 2'd2; #1;
    total++; if (dbg_rdata !== 8'h00) begin bad++; $display("FAIL mid_rf2 got=%h exp=00", dbg_rdata); end
    for (int i = 0; i < 4; i++) model_rf[i] = 8'h00;
  endtask

  task automatic test_random();
    int lat; logic [7:0] r; logic c, z; logic [1:0] rd; bit to;
    logic ld; logic [2:0] op; logic [1:0] d, sa, sb; logic [7:0] imm; logic [8:0] exp; int stall;
    int nbad0;
    nbad0 = bad;
    for (int k = 0; k < 60; k++) begin
      ld    = (k < 4) || ($urandom_range(0, 3) == 0);
      op    = 3'($urandom);
      d     = (k < 4) ? 2'(k) : 2'($urandom);
      sa    = 2'($urandom);
      sb    = 2'($urandom);
      imm   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      stall = $urandom_range(0, 3);
      exp   = ld ? {1'b0, imm} : alu_ref(op, model_rf[sa], model_rf[sb]);
      do_cmd(ld, op, d, sa, sb, imm, stall, lat, r, c, z, rd, to);
      total++; if (to || lat != (ld ? 0 : 2)) begin
        bad++; $display("FAIL rnd%0d_latency to=%0d got=%0d exp=%0d", k, to, lat, ld ? 0 : 2); end
      total++; if ({c, r} !== exp || z !== (exp[7:0] == 8'h00) || rd !== d) begin
        bad++; $display("FAIL rnd%0d_rsp ld=%b op=%0d got r=%h c=%b z=%b d=%0d exp r=%h c=%b z=%b d=%0d",
                        k, ld, op, r, c, z, rd, exp[7:0], exp[8], exp[7:0] == 8'h00, d); end
      model_rf[d] = exp[7:0];
      dbg_raddr = 2'($urandom);
      #1;
      total++; if (dbg_rdata !== model_rf[dbg_raddr]) begin
        bad++; $display("FAIL rnd%0d_rf[%0d] got=%h exp=%h", k, dbg_raddr, dbg_rdata, model_rf[dbg_raddr]); end
    end
    if (bad != nbad0) $display("random section errors=%0d", bad - nbad0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_xor();
    test_backpressure();
    test_reserved_not();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
